wb_arbiter_2to1: RTL and testbench

- Two-master, one-slave arbiter for pipelined Wishbone (cyc/stb/stall/ack/err/rty) buses built on wishbone_if.
- Sits between two bus masters (e.g. instruction and data ports of the core) and one shared slave port (e.g. main memory or peripheral interconnect).
- Round-robin grant, held for the whole cyc period.
- Tracks outstanding requests so responses always route to the master that issued them.

---
 rtl/wb_arbiter_2to1_if.sv | 28 ++
 rtl/wb_arbiter_2to1.sv | 172 +++++++++++++++++
 tb/tb_wb_arbiter_2to1.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_2to1_if.sv
// Pipelined Wishbone bus bundle (cyc/stb/stall/ack/err/rty) shared by the
// arbiter's two master-facing ports and its slave-facing port.
interface wishbone_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      stall;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport MASTER (
    output cyc, stb, we, addr, sel, wdata,
    input  rdata, stall, ack, err, rty
  );

  modport SLAVE (
    input  cyc, stb, we, addr, sel, wdata,
    output rdata, stall, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_2to1.sv
// Two-master / one-slave pipelined Wishbone arbiter.
// Round-robin grant held for a whole cyc period, registered (one bubble cycle
// in IDLE). An outstanding-request counter caps the pipeline depth and drops
// responses that arrive with nothing outstanding.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort a silent slave after
// TIMEOUT_CYCLES cycles and return a single err to the owning master.
module wb_arbiter_2to1 #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  wishbone_if.SLAVE  m0_wb,
  wishbone_if.SLAVE  m1_wb,
  wishbone_if.MASTER s_wb
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SelW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_last_grant, w_last_grant_nxt;
  logic [CntW-1:0]          r_outstanding, w_outstanding_nxt;

  logic                     w_own0, w_own1;
  logic                     w_cyc, w_stb, w_we;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [SelW-1:0]          w_sel;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic                     w_s_cyc, w_s_stb;
  logic                     w_limit, w_have_out, w_resp, w_accept, w_timeout;
  logic                     w_m_stall, w_m_ack, w_m_err, w_m_rty;

  assign w_own0     = (r_state == GNT0);
  assign w_own1     = (r_state == GNT1);
  assign w_limit    = (r_outstanding == CntW'(MAX_OUTSTANDING));
  assign w_have_out = (r_outstanding != '0);
  assign w_resp     = (s_wb.ack | s_wb.err | s_wb.rty) & w_have_out;

  // Select the owning master's request signals; nothing is driven in IDLE.
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_sel   = '0;
    w_wdata = '0;
    unique case (r_state)
      GNT0: begin
        w_cyc   = m0_wb.cyc;
        w_stb   = m0_wb.stb;
        w_we    = m0_wb.we;
        w_addr  = m0_wb.addr;
        w_sel   = m0_wb.sel;
        w_wdata = m0_wb.wdata;
      end
      GNT1: begin
        w_cyc   = m1_wb.cyc;
        w_stb   = m1_wb.stb;
        w_we    = m1_wb.we;
        w_addr  = m1_wb.addr;
        w_sel   = m1_wb.sel;
        w_wdata = m1_wb.wdata;
      end
      default: ;
    endcase
  end

  assign w_s_cyc  = w_cyc & ~w_timeout;
  assign w_s_stb  = w_stb & ~w_limit & ~w_timeout;
  assign w_accept = w_s_cyc & w_s_stb & ~s_wb.stall;

  assign s_wb.cyc   = w_s_cyc;
  assign s_wb.stb   = w_s_stb;
  assign s_wb.we    = w_we;
  assign s_wb.addr  = w_addr;
  assign s_wb.sel   = w_sel;
  assign s_wb.wdata = w_wdata;

  // The abort cycle also stalls the owner so no request is lost while s_wb.cyc is low.
  assign w_m_stall = s_wb.stall | w_limit | w_timeout;
  assign w_m_ack   = s_wb.ack & w_have_out;
  assign w_m_err   = (s_wb.err & w_have_out) | w_timeout;
  assign w_m_rty   = s_wb.rty & w_have_out;

  assign m0_wb.stall = w_own0 ? w_m_stall : 1'b1;
  assign m0_wb.ack   = w_own0 & w_m_ack;
  assign m0_wb.err   = w_own0 & w_m_err;
  assign m0_wb.rty   = w_own0 & w_m_rty;
  assign m0_wb.rdata = w_own0 ? s_wb.rdata : '0;

  assign m1_wb.stall = w_own1 ? w_m_stall : 1'b1;
  assign m1_wb.ack   = w_own1 & w_m_ack;
  assign m1_wb.err   = w_own1 & w_m_err;
  assign m1_wb.rty   = w_own1 & w_m_rty;
  assign m1_wb.rdata = w_own1 ? s_wb.rdata : '0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] r_wdog;
  logic           w_wdog_run;

  assign w_wdog_run = (r_state != IDLE) & w_have_out & ~w_resp;
  assign w_timeout  = w_wdog_run & (r_wdog == WdW'(TIMEOUT_CYCLES - 1));

  // Count silent cycles while requests are pending; any response or abort restarts it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wdog <= '0;
    end else if (w_wdog_run & ~w_timeout) begin
      r_wdog <= r_wdog + WdW'(1);
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Grant state, round-robin pointer and outstanding-request count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Arbitrate in IDLE; hold the grant until the owner drops cyc; track the pipeline depth.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_grant_nxt  = r_last_grant;
    w_outstanding_nxt = r_outstanding;
    unique case (r_state)
      IDLE: begin
        w_outstanding_nxt = '0;
        if (m0_wb.cyc & m1_wb.cyc) begin
          w_state_nxt      = r_last_grant ? GNT0 : GNT1;
          w_last_grant_nxt = ~r_last_grant;
        end else if (m0_wb.cyc) begin
          w_state_nxt      = GNT0;
          w_last_grant_nxt = 1'b0;
        end else if (m1_wb.cyc) begin
          w_state_nxt      = GNT1;
          w_last_grant_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!w_cyc) begin
          w_state_nxt       = IDLE;
          w_outstanding_nxt = '0;
        end else if (w_timeout) begin
          w_outstanding_nxt = '0;
        end else if (w_accept & ~w_resp) begin
          w_outstanding_nxt = r_outstanding + CntW'(1);
        end else if (~w_accept & w_resp) begin
          w_outstanding_nxt = r_outstanding - CntW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: random masters and slave checked
// every cycle against a transaction-level model (owner + queue of pending
// request addresses), plus directed tie/round-robin, limit, reset and
// (with WB_ARB_TIMEOUT_EN) watchdog scenarios.
`timescale 1ns/1ps
module tb_wb_arbiter_2to1;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 4;
  localparam int unsigned TMO  = 16;

  logic clk_i;
  logic rstn_i;

  wishbone_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  wishbone_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  wishbone_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

  wb_arbiter_2to1 #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .m0_wb(m0_if),
    .m1_wb(m1_if),
    .s_wb(s_if)
  );

  // bench-driven stimulus
  logic            b_cyc[2], b_stb[2], b_we[2];
  logic [AW-1:0]   b_addr[2];
  logic [DW/8-1:0] b_sel[2];
  logic [DW-1:0]   b_wdata[2];
  logic            b_sstall, b_sack, b_serr, b_srty;
  logic [DW-1:0]   b_srdata;

  assign m0_if.cyc = b_cyc[0];   assign m1_if.cyc = b_cyc[1];
  assign m0_if.stb = b_stb[0];   assign m1_if.stb = b_stb[1];
  assign m0_if.we  = b_we[0];    assign m1_if.we  = b_we[1];
  assign m0_if.addr = b_addr[0]; assign m1_if.addr = b_addr[1];
  assign m0_if.sel = b_sel[0];   assign m1_if.sel = b_sel[1];
  assign m0_if.wdata = b_wdata[0]; assign m1_if.wdata = b_wdata[1];
  assign s_if.stall = b_sstall;
  assign s_if.ack   = b_sack;
  assign s_if.err   = b_serr;
  assign s_if.rty   = b_srty;
  assign s_if.rdata = b_srdata;

  // observed master-side returns
  logic          o_stall[2], o_ack[2], o_err[2], o_rty[2];
  logic [DW-1:0] o_rdata[2];
  assign o_stall[0] = m0_if.stall; assign o_stall[1] = m1_if.stall;
  assign o_ack[0]   = m0_if.ack;   assign o_ack[1]   = m1_if.ack;
  assign o_err[0]   = m0_if.err;   assign o_err[1]   = m1_if.err;
  assign o_rty[0]   = m0_if.rty;   assign o_rty[1]   = m1_if.rty;
  assign o_rdata[0] = m0_if.rdata; assign o_rdata[1] = m1_if.rdata;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_total;
  int unsigned n_bad;

  // reference model: owner (-1 none), last winner, pending request addresses, silent-cycle count
  int            mo_owner;
  int            mo_last;
  int            mo_wd;
  logic [AW-1:0] mo_q[$];
  bit            e_acc, e_rsp, e_tmo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = 1;
    mo_wd    = 0;
    mo_q.delete();
    e_acc = 0; e_rsp = 0; e_tmo = 0;
  endtask

  // Compare every DUT output with the model for the current inputs.
  task automatic model_check();
    int x;
    bit have, lim, rsp, tmo, scyc, sstb;
    x    = mo_owner;
    have = (mo_q.size() > 0);
    lim  = (mo_q.size() == MAXO);
    rsp  = have && (b_sack || b_serr || b_srty);
    tmo  = 0;
`ifdef WB_ARB_TIMEOUT_EN
    tmo  = (x >= 0) && have && !rsp && (mo_wd == TMO - 1);
`endif
    if (x < 0) begin
      scyc = 0;
      sstb = 0;
    end else begin
      scyc = b_cyc[x] && !tmo;
      sstb = b_stb[x] && !lim && !tmo;
      check_eq("s_we", s_if.we, b_we[x]);
      check_eq("s_addr", s_if.addr, b_addr[x]);
      check_eq("s_sel", s_if.sel, b_sel[x]);
      check_eq("s_wdata", s_if.wdata, b_wdata[x]);
    end
    check_eq("s_cyc", s_if.cyc, scyc);
    check_eq("s_stb", s_if.stb, sstb);
    for (int m = 0; m < 2; m++) begin
      if (m == x) begin
        check_eq($sformatf("m%0d_stall", m), o_stall[m], b_sstall || lim || tmo);
        check_eq($sformatf("m%0d_ack", m), o_ack[m], have && b_sack);
        check_eq($sformatf("m%0d_err", m), o_err[m], (have && b_serr) || tmo);
        check_eq($sformatf("m%0d_rty", m), o_rty[m], have && b_srty);
        check_eq($sformatf("m%0d_rdata", m), o_rdata[m], b_srdata);
      end else begin
        check_eq($sformatf("m%0d_stall_idle", m), o_stall[m], 1'b1);
        check_eq($sformatf("m%0d_ack_idle", m), o_ack[m], 1'b0);
        check_eq($sformatf("m%0d_err_idle", m), o_err[m], 1'b0);
        check_eq($sformatf("m%0d_rty_idle", m), o_rty[m], 1'b0);
        check_eq($sformatf("m%0d_rdata_idle", m), o_rdata[m], '0);
      end
    end
    e_acc = scyc && sstb && !b_sstall;
    e_rsp = rsp;
    e_tmo = tmo;
  endtask

  // Advance the model across one rising edge using the inputs of the cycle just checked.
  task automatic model_update();
    int x;
    bit had;
    x = mo_owner;
    if (x < 0) begin
      if (b_cyc[0] && b_cyc[1]) x = (mo_last == 0) ? 1 : 0;
      else if (b_cyc[0])        x = 0;
      else if (b_cyc[1])        x = 1;
      if (x >= 0) mo_last = x;
      mo_owner = x;
      mo_q.delete();
      mo_wd = 0;
    end else if (!b_cyc[x]) begin
      mo_owner = -1;
      mo_q.delete();
      mo_wd = 0;
    end else if (e_tmo) begin
      mo_q.delete();
      mo_wd = 0;
    end else begin
      had = (mo_q.size() > 0);
      if (e_rsp) void'(mo_q.pop_front());
      if (e_acc) mo_q.push_back(b_addr[x]);
      mo_wd = (had && !e_rsp) ? mo_wd + 1 : 0;
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk_i);
    if (rstn_i) model_update();
    #1;
  endtask

  task automatic cycle_end();
    @(negedge clk_i);
    model_check();
  endtask

  task automatic slave_quiet();
    b_sstall = 0; b_sack = 0; b_serr = 0; b_srty = 0; b_srdata = '0;
  endtask

  task automatic drive_random();
    int r;
    bit respond;
    for (int m = 0; m < 2; m++) begin
      if (!b_cyc[m]) b_cyc[m] = ($urandom_range(0, 99) < 30);
      else if ($urandom_range(0, 99) < 8) b_cyc[m] = 1'b0;
      b_stb[m]   = b_cyc[m] && ($urandom_range(0, 99) < 60);
      b_we[m]    = ($urandom_range(0, 1) == 1);
      b_addr[m]  = $urandom & ~32'h3;
      b_sel[m]   = 4'($urandom_range(0, 15));
      b_wdata[m] = $urandom;
    end
    slave_quiet();
    b_sstall = ($urandom_range(0, 99) < 25);
    respond  = (mo_q.size() > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 5);
    if (respond) begin
      r = $urandom_range(0, 9);
      if (r < 7)      b_sack = 1;
      else if (r < 9) b_serr = 1;
      else            b_srty = 1;
    end
    b_srdata = (mo_q.size() > 0) ? data_of(mo_q[0]) : $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      b_cyc[0] = 0; b_cyc[1] = 0; b_stb[0] = 0; b_stb[1] = 0;
      slave_quiet();
      cycle_end();
    end
  endtask

  int n_acc;
  int first_err;
  int n_err;
  bit acc_seen;

  initial begin
    #500us;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rstn_i  = 0;
    for (int m = 0; m < 2; m++) begin
      b_cyc[m] = 0; b_stb[m] = 0; b_we[m] = 0; b_addr[m] = '0; b_sel[m] = '0; b_wdata[m] = '0;
    end
    slave_quiet();
    model_reset();

    // reset state
    cycle_end();
    cycle_end();
    rstn_i = 1;

    // simultaneous request after reset goes to m0
    cycle_begin(); b_cyc[0] = 1; b_cyc[1] = 1; cycle_end();
    check_eq("bubble_m0_stall", o_stall[0], 1'b1);
    cycle_begin(); cycle_end();
    check_eq("tie_m0_granted", o_stall[0], 1'b0);
    check_eq("tie_m1_waits", o_stall[1], 1'b1);
    // m0 releases while m1 still requests -> m1
    cycle_begin(); b_cyc[0] = 0; cycle_end();
    cycle_begin(); cycle_end();
    cycle_begin(); cycle_end();
    check_eq("rr_m1_granted", o_stall[1], 1'b0);
    // m1 releases, both request together -> m0 again
    cycle_begin(); b_cyc[1] = 0; cycle_end();
    cycle_begin(); b_cyc[0] = 1; b_cyc[1] = 1; cycle_end();
    cycle_begin(); cycle_end();
    check_eq("rr_m0_regranted", o_stall[0], 1'b0);
    check_eq("rr_m1_waits", o_stall[1], 1'b1);

    // random traffic, with an asynchronous reset pulse in the middle of a burst
    for (int i = 0; i < 2000; i++) begin
      cycle_begin();
      drive_random();
      if (i == 700) begin
        #2;
        rstn_i = 0;
        #1;
        model_reset();
        model_check();
      end
      cycle_end();
      if (!rstn_i) rstn_i = 1;
    end

    // outstanding limit with a silent slave
    drain();
    n_acc = 0;
    for (int k = 0; k < 9; k++) begin
      cycle_begin();
      b_cyc[0] = 1; b_stb[0] = 1; b_addr[0] = 32'h100 + 32'(4 * k);
      slave_quiet();
      cycle_end();
      if (s_if.cyc && s_if.stb && !s_if.stall) n_acc++;
    end
    check_eq("limit_accepts", n_acc, 4);
    check_eq("limit_m0_stall", o_stall[0], 1'b1);
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      cycle_begin();
      slave_quiet();
      if (k == 0) begin
        b_sack = 1;
        b_srdata = data_of(mo_q[0]);
      end
      cycle_end();
      if (s_if.cyc && s_if.stb && !s_if.stall) n_acc++;
    end
    check_eq("limit_after_one_ack", n_acc, 1);
    drain();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: one accepted request, slave never answers, late ack afterwards
    acc_seen = 0;
    for (int k = 0; k < 10 && !acc_seen; k++) begin
      cycle_begin();
      b_cyc[0] = 1; b_stb[0] = 1; b_addr[0] = 32'h200;
      slave_quiet();
      cycle_end();
      if (s_if.cyc && s_if.stb && !s_if.stall) acc_seen = 1;
    end
    check_eq("tmo_accept_seen", acc_seen, 1'b1);
    first_err = -1;
    n_err = 0;
    for (int k = 1; k <= 24; k++) begin
      cycle_begin();
      b_stb[0] = 0;
      slave_quiet();
      if (k == 20) b_sack = 1;
      cycle_end();
      if (o_err[0]) begin
        n_err++;
        if (first_err < 0) first_err = k;
      end
      if (k == 20) check_eq("late_ack_dropped", o_ack[0], 1'b0);
    end
    check_eq("tmo_err_cycle", first_err, 16);
    check_eq("tmo_err_pulses", n_err, 1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
